// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage with load extension, source select, halt FSM and retire counter
module wb_stage #(
   parameter int NB_DATA     = 32,
   parameter int NB_PC       = 32,
   parameter int NB_REG      = 5,
   parameter int NB_COUNT    = 32,
   parameter int LINK_OFFSET = 1
) (
   input  logic                i_clock,
   input  logic                i_WB_reset,
   input  logic                i_WB_enable,
   input  logic                i_WB_valid,
   input  logic                i_WB_reg_write,
   input  logic                i_WB_mem_to_reg,
   input  logic                i_WB_link,
   input  logic                i_WB_halt,
   input  logic [NB_DATA-1:0]  i_WB_mem_data,
   input  logic [NB_DATA-1:0]  i_WB_alu_result,
   input  logic [NB_PC-1:0]    i_WB_pc,
   input  logic [NB_REG-1:0]   i_WB_write_reg,
   input  logic                i_WB_byte_en,
   input  logic                i_WB_halfword_en,
   input  logic                i_WB_word_en,
   input  logic                i_WB_unsigned,
   input  logic [1:0]          i_WB_byte_offset,
   output logic [NB_DATA-1:0]  o_WB_write_data,
   output logic [NB_REG-1:0]   o_WB_write_reg,
   output logic                o_WB_reg_write,
   output logic                o_WB_halt,
   output logic [NB_COUNT-1:0] o_WB_retired
);
   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] HALTED = 1'b1;
   logic [0:0]          state;
   logic                valid_q, reg_write_q, mem_to_reg_q, link_q, halt_q;
   logic                byte_q, half_q, word_q, unsigned_q;
   logic [1:0]          offset_q;
   logic [NB_DATA-1:0]  mem_q, alu_q;
   logic [NB_PC-1:0]    pc_q;
   logic [NB_REG-1:0]   wreg_q;
   logic [NB_COUNT-1:0] count;
   logic                capture;
   logic [7:0]          lane8;
   logic [15:0]         lane16;
   logic [NB_DATA-1:0]  load_data;
   logic [NB_PC-1:0]    link_addr;
   assign capture   = i_WB_enable && state == RUN;
   assign link_addr = pc_q + NB_PC'(LINK_OFFSET);
   assign lane8     = mem_q[8*offset_q +: 8];
   assign lane16    = offset_q[1] ? mem_q[31:16] : mem_q[15:0];
   // load extension: word wins, then halfword, then byte; no size enable behaves as word
   always_comb begin
      load_data = (word_q || !(half_q || byte_q)) ? mem_q
                : half_q ? {{(NB_DATA-16){!unsigned_q && lane16[15]}}, lane16}
                : {{(NB_DATA-8){!unsigned_q && lane8[7]}}, lane8};
   end
   assign o_WB_write_data = link_q ? NB_DATA'(link_addr) : mem_to_reg_q ? load_data : alu_q;
   assign o_WB_write_reg  = wreg_q;
   assign o_WB_reg_write  = reg_write_q && valid_q && wreg_q != '0 && state == RUN && !halt_q;
   assign o_WB_halt       = state == HALTED;
   assign o_WB_retired    = count;
   // MEM/WB register, saturating retire counter and halt FSM
   always_ff @(posedge i_clock) begin
      if (i_WB_reset) begin
         state        <= RUN;
         count        <= '0;
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         link_q       <= 1'b0;
         halt_q       <= 1'b0;
         byte_q       <= 1'b0;
         half_q       <= 1'b0;
         word_q       <= 1'b0;
         unsigned_q   <= 1'b0;
         offset_q     <= '0;
         mem_q        <= '0;
         alu_q        <= '0;
         pc_q         <= '0;
         wreg_q       <= '0;
      end else begin
         if (capture) begin
            valid_q      <= i_WB_valid;
            reg_write_q  <= i_WB_reg_write;
            mem_to_reg_q <= i_WB_mem_to_reg;
            link_q       <= i_WB_link;
            halt_q       <= i_WB_halt;
            byte_q       <= i_WB_byte_en;
            half_q       <= i_WB_halfword_en;
            word_q       <= i_WB_word_en;
            unsigned_q   <= i_WB_unsigned;
            offset_q     <= i_WB_byte_offset;
            mem_q        <= i_WB_mem_data;
            alu_q        <= i_WB_alu_result;
            pc_q         <= i_WB_pc;
            wreg_q       <= i_WB_write_reg;
            if (i_WB_valid && !i_WB_halt && count != '1)
               count <= count + 1'b1;
         end
         if (state == RUN && valid_q && halt_q)
            state <= HALTED;
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage
module tb_wb_stage;
   typedef struct {
      logic [31:0] d;
      logic [4:0]  r;
      logic        w;
      logic        h;
      logic [31:0] n;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, valid = 1'b0, rw = 1'b0, m2r = 1'b0, link = 1'b0, halt = 1'b0;
   logic [31:0] mem = '0, alu = '0, pc = '0;
   logic [4:0]  wreg = '0;
   logic        be = 1'b0, he = 1'b0, we = 1'b0, uns = 1'b0;
   logic [1:0]  off = '0;
   logic [31:0] wd, ret;
   logic [4:0]  wr;
   logic        wen, hlt;
   exp_t        q[$];
   int          n_chk = 0, n_fail = 0, vec = 0;
   wb_stage dut (
      .i_clock(clk), .i_WB_reset(rst), .i_WB_enable(en), .i_WB_valid(valid),
      .i_WB_reg_write(rw), .i_WB_mem_to_reg(m2r), .i_WB_link(link), .i_WB_halt(halt),
      .i_WB_mem_data(mem), .i_WB_alu_result(alu), .i_WB_pc(pc), .i_WB_write_reg(wreg),
      .i_WB_byte_en(be), .i_WB_halfword_en(he), .i_WB_word_en(we), .i_WB_unsigned(uns),
      .i_WB_byte_offset(off), .o_WB_write_data(wd), .o_WB_write_reg(wr),
      .o_WB_reg_write(wen), .o_WB_halt(hlt), .o_WB_retired(ret)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int v, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL vec%0d %s: got %h expected %h", v, nm, a, e);
      end
   endtask
   // monitor: one expectation per cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("write_data", vec, wd, e.d);
         chk("write_reg", vec, {27'd0, wr}, {27'd0, e.r});
         chk("reg_write", vec, {31'd0, wen}, {31'd0, e.w});
         chk("halt", vec, {31'd0, hlt}, {31'd0, e.h});
         chk("retired", vec, ret, e.n);
         vec++;
      end
   end
   task automatic cyc(input logic [31:0] d, input logic [4:0] r, input logic w, input logic h, input logic [31:0] n);
      exp_t e;
      @(posedge clk);
      #1;
      e.d = d; e.r = r; e.w = w; e.h = h; e.n = n;
      q.push_back(e);
   endtask
   task automatic load(input logic b, input logic hw, input logic wd_en, input logic u, input logic [1:0] o);
      be = b; he = hw; we = wd_en; uns = u; off = o;
   endtask
   initial begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0);
      en = 1; valid = 1; rw = 1; alu = 32'h0000_1234; wreg = 5;
      cyc(32'h0000_1234, 5, 1, 0, 1);
      m2r = 1; mem = 32'h80FF_7F01; wreg = 6;
      load(1, 0, 0, 0, 3); cyc(32'hFFFF_FF80, 6, 1, 0, 2);
      load(1, 0, 0, 1, 3); cyc(32'h0000_0080, 6, 1, 0, 3);
      load(0, 1, 0, 0, 2); cyc(32'hFFFF_80FF, 6, 1, 0, 4);
      load(0, 1, 0, 1, 0); cyc(32'h0000_7F01, 6, 1, 0, 5);
      load(0, 0, 1, 0, 1); cyc(32'h80FF_7F01, 6, 1, 0, 6);
      load(0, 0, 0, 1, 1); cyc(32'h80FF_7F01, 6, 1, 0, 7);
      load(1, 1, 0, 0, 3); cyc(32'hFFFF_80FF, 6, 1, 0, 8);
      load(1, 0, 1, 1, 2); cyc(32'h80FF_7F01, 6, 1, 0, 9);
      load(1, 0, 0, 0, 1); cyc(32'h0000_007F, 6, 1, 0, 10);
      load(1, 0, 0, 0, 0); cyc(32'h0000_0001, 6, 1, 0, 11);
      load(0, 0, 0, 0, 0);
      m2r = 0; link = 1; pc = 32'h0000_0010; wreg = 31;
      cyc(32'h0000_0011, 31, 1, 0, 12);
      m2r = 1; pc = 32'hFFFF_FFFF;
      cyc(32'h0000_0000, 31, 1, 0, 13);
      m2r = 0; link = 0; alu = 32'h0000_DEAD; wreg = 0;
      cyc(32'h0000_DEAD, 0, 0, 0, 14);
      alu = 32'h55; wreg = 7;
      cyc(32'h55, 7, 1, 0, 15);
      en = 0; alu = 32'h99; wreg = 12;
      cyc(32'h55, 7, 1, 0, 15);
      cyc(32'h55, 7, 1, 0, 15);
      cyc(32'h55, 7, 1, 0, 15);
      en = 1; valid = 0; alu = 32'h77; wreg = 8;
      cyc(32'h77, 8, 0, 0, 15);
      valid = 1; rw = 0; alu = 32'h66; wreg = 9;
      cyc(32'h66, 9, 0, 0, 16);
      rw = 1; halt = 1; alu = 32'h42; wreg = 10;
      cyc(32'h42, 10, 0, 0, 16);
      en = 0;
      cyc(32'h42, 10, 0, 1, 16);
      en = 1; halt = 0; alu = 32'h11; wreg = 11;
      cyc(32'h42, 10, 0, 1, 16);
      cyc(32'h42, 10, 0, 1, 16);
      rst = 1;
      cyc(0, 0, 0, 0, 0);
      rst = 0; en = 0;
      cyc(0, 0, 0, 0, 0);
      en = 1; alu = 32'h3; wreg = 2;
      cyc(32'h3, 2, 1, 0, 1);
      @(negedge clk);
      @(posedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline, and the producer side of the decode-stage register-bank write port.
- Registers the MEM/WB boundary and extracts and extends load data for byte, halfword and word accesses.
- Selects the link, memory or ALU value for the write-back data.
- Drives write data, write address and write enable into the register bank.
- Tracks halt and retired-instruction count for the debug unit.

Parameters:
NB_DATA, 32, data path width
NB_PC, 32, PC width
NB_REG, 5, register address width
NB_COUNT, 32, retired-instruction counter width
LINK_OFFSET, 1, value added to latched PC to form jal/jalr return address (word-addressed PC)

Ports:
i_clock  in  1  system clock
i_WB_reset  in  1  synchronous active-high reset
i_WB_enable  in  1  pipeline advance; 0 = hold MEM/WB register
i_WB_valid  in  1  MEM stage carries a real instruction (0 = bubble)
i_WB_reg_write  in  1  instruction writes a register
i_WB_mem_to_reg  in  1  1 = write-back source is memory data
i_WB_link  in  1  jal/jalr: write return address
i_WB_halt  in  1  halt instruction marker
i_WB_mem_data  in  NB_DATA  raw memory word
i_WB_alu_result  in  NB_DATA  ALU result
i_WB_pc  in  NB_PC  PC of instruction
i_WB_write_reg  in  NB_REG  destination register
i_WB_byte_en, i_WB_halfword_en, i_WB_word_en  in  1 each  load size (one-hot)
i_WB_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
i_WB_byte_offset  in  2  alu_result[1:0] of the load address
o_WB_write_data  out  NB_DATA  to register bank write data
o_WB_write_reg  out  NB_REG  to register bank write address
o_WB_reg_write  out  1  to register bank write enable
o_WB_halt  out  1  processor halted
o_WB_retired  out  NB_COUNT  retired-instruction count

Behaviour:
- Clock: single clock i_clock.
- Reset: i_WB_reset is synchronous and active-high.
- Reset values:
  - MEM/WB register all zero, valid=0.
  - FSM = RUN, counter = 0.
  - Outputs: write_data=0, write_reg=0, reg_write=0, halt=0, retired=0.
- MEM/WB register: on a rising edge with enable=1 and FSM=RUN, latch all i_WB_* inputs; otherwise hold.
- Latency: outputs are combinational from the latched register, so they are valid 1 cycle after capture.
- Load extraction, applied only when the latched mem_to_reg=1:
  - byte: lane = mem_data[8*offset+7 : 8*offset]; extend bit 7 (signed) or zero-extend (unsigned).
  - halfword: offset[1]=0 -> [15:0], offset[1]=1 -> [31:16]; extend bit 15 or zero-extend; offset[0] is ignored.
  - word: mem_data unchanged; offset and unsigned are ignored.
  - No size enable asserted: treat as word.
  - More than one size enable asserted: priority word > halfword > byte.
- Source select priority: link (pc + LINK_OFFSET, wraps mod 2^NB_PC) > mem_to_reg (extracted load data) > alu_result.
- o_WB_write_reg = latched write_reg.
- o_WB_reg_write = latched reg_write AND latched valid AND write_reg != 0 AND FSM=RUN AND NOT latched halt. Writes to r0 are always suppressed.
- FSM states:
  - RUN: normal operation.
  - HALTED: entered from RUN on the cycle after the latched word has valid=1 and halt=1.
  - In HALTED: o_WB_halt=1, reg_write=0, MEM/WB register frozen, counter frozen, enable ignored.
  - Exit from HALTED: only by reset.
  - While the halt instruction sits in WB (before the transition), halt=0 and reg_write=0.
- Retired counter:
  - Increments by 1 at each capture edge (enable=1, FSM=RUN) where i_WB_valid=1 and i_WB_halt=0.
  - Bubbles and the halt instruction are not counted.
  - Saturates at 2^NB_COUNT-1 (no wrap).
- Stall: with enable=0 the same instruction is presented for multiple cycles; the repeated register-bank write is idempotent and the counter does not re-increment.
- Reset mid-operation, including in HALTED: all state clears on that edge.

Test Plan:
1. Reset asserted 2 cycles then released -> all outputs 0; FSM RUN.
2. ALU write: alu_result=0x0000_1234, write_reg=5, reg_write=1, valid=1, enable=1 -> next cycle write_data=0x1234, write_reg=5, reg_write=1; retired=1.
3. Loads with mem_data=0x80FF_7F01:
   - lb offset 3 -> 0xFFFF_FF80
   - lbu offset 3 -> 0x0000_0080
   - lh offset 2 -> 0xFFFF_80FF
   - lhu offset 0 -> 0x0000_7F01
   - lw -> 0x80FF_7F01
4. Link and r0:
   - jal with pc=0x0000_0010, write_reg=31 -> write_data=0x0000_0011, reg_write=1.
   - write_reg=0 with reg_write=1 -> reg_write=0.
5. Stall and bubble:
   - enable=0 for 3 cycles after capturing an instruction -> outputs stable, retired unchanged.
   - valid=0 capture -> reg_write=0, retired unchanged.
6. Halt:
   - Capture halt=1, valid=1 -> halt stays 0 that cycle, o_WB_halt=1 the next cycle.
   - Further captures ignored, retired frozen.
   - Reset -> halt=0, retired=0.
